// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit groups with group P/G and per-group
// conditional sums, then a flat second-level lookahead that selects the final group sums.
module cla_pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             P,
  output logic             G,
  output logic             ovf
);
  localparam int NG = WIDTH / 4;
  localparam int MW = 2 * WIDTH + 2 * NG + 4;

  // Handshake: a beat moves on a posedge with valid && ready on that side. All ranks
  // advance together on en, so a stalled output freezes the whole pipe, bubbles included.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = !rst && en;

  // Input rank
  logic             v0_d, v0_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic             cin_d, cin_q, sub_d, sub_q;

  always_comb begin
    v0_d  = v0_q;
    a_d   = a_q;
    b_d   = b_q;
    cin_d = cin_q;
    sub_d = sub_q;
    if (en) begin
      v0_d = in_valid;
      if (in_valid) begin
        a_d   = A;
        b_d   = B;
        cin_d = cin;
        sub_d = sub;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      v0_q  <= v0_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
      sub_q <= sub_d;
    end
  end

  // Group level: propagate/generate and both candidate sums for every 4-bit group
  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] gs0, gs1;
  logic [NG-1:0]    gp, gg;
  logic [4:0]       t0;
  logic [3:0]       t1;

  always_comb begin
    beff = sub_q ? ~b_q : b_q;
    gs0  = '0;
    gs1  = '0;
    gp   = '0;
    gg   = '0;
    t0   = '0;
    t1   = '0;
    for (int j = 0; j < NG; j++) begin
      t0             = {1'b0, a_q[4*j +: 4]} + {1'b0, beff[4*j +: 4]};
      t1             = t0[3:0] + 4'd1;
      gs0[4*j +: 4]  = t0[3:0];
      gs1[4*j +: 4]  = t1;
      gg[j]          = t0[4];
      gp[j]          = &(a_q[4*j +: 4] ^ beff[4*j +: 4]);
    end
  end

  logic [MW-1:0] s1_vec, mid;
  assign s1_vec = {v0_q, sub_q | cin_q, a_q[WIDTH-1], beff[WIDTH-1], gp, gg, gs1, gs0};

  generate
    if (PIPE != 0) begin : g_mid
      logic [MW-1:0] mid_d, mid_q;
      always_comb begin
        mid_d = mid_q;
        if (en) mid_d = s1_vec;
      end
      always_ff @(posedge clk) begin
        if (rst) mid_q <= '0;
        else     mid_q <= mid_d;
      end
      assign mid = mid_q;
    end else begin : g_nomid
      assign mid = s1_vec;
    end
  endgenerate

  logic             m_v, m_c0, m_amsb, m_bmsb;
  logic [NG-1:0]    m_gp, m_gg;
  logic [WIDTH-1:0] m_gs1, m_gs0;
  assign {m_v, m_c0, m_amsb, m_bmsb, m_gp, m_gg, m_gs1, m_gs0} = mid;

  // Second level: every group carry is a flat sum of products of group P/G, never a ripple
  logic [NG:0]      carry;
  logic             gen_all, term;
  logic [WIDTH-1:0] sum;

  always_comb begin
    carry    = '0;
    carry[0] = m_c0;
    gen_all  = 1'b0;
    term     = 1'b0;
    sum      = '0;
    for (int j = 1; j <= NG; j++) begin
      term = m_c0;
      for (int k = 0; k < j; k++) term = term & m_gp[k];
      carry[j] = term;
      for (int i = 0; i < j; i++) begin
        term = m_gg[i];
        for (int k = i + 1; k < j; k++) term = term & m_gp[k];
        carry[j] = carry[j] | term;
        if (j == NG) gen_all = gen_all | term;
      end
    end
    for (int j = 0; j < NG; j++)
      sum[4*j +: 4] = carry[j] ? m_gs1[4*j +: 4] : m_gs0[4*j +: 4];
  end

  // Output rank
  logic             ov_d, ov_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q, p_d, p_q, g_d, g_q, ovf_d, ovf_q;

  always_comb begin
    ov_d   = ov_q;
    s_d    = s_q;
    cout_d = cout_q;
    p_d    = p_q;
    g_d    = g_q;
    ovf_d  = ovf_q;
    if (en) begin
      ov_d = m_v;
      if (m_v) begin
        s_d    = sum;
        cout_d = carry[NG];
        p_d    = &m_gp;
        g_d    = gen_all;
        ovf_d  = (m_amsb == m_bmsb) && (sum[WIDTH-1] != m_amsb);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      p_q    <= 1'b0;
      g_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ov_q   <= ov_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      p_q    <= p_d;
      g_q    <= g_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = ov_q;
  assign S         = s_q;
  assign cout      = cout_q;
  assign P         = p_q;
  assign G         = g_q;
  assign ovf       = ovf_q;
endmodule
